// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: state encoding,
// field widths and the control bundle driven onto the pipeline registers.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W  = 5;   // register index width
  localparam int CNT_W  = 32;  // statistics counter width
  localparam int WAIT_W = 16;  // memory wait counter width
  localparam int INIT_W = 4;   // init counter width (INIT_CYCLES up to 15)

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } hz_ctrl_t;

  // Priming: nothing advances, every register loads a bubble.
  function automatic hz_ctrl_t ctrl_init();
    hz_ctrl_t c;
    c = '{pc_write: 1'b0, pc_src: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
          exmem_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1,
          exmem_flush: 1'b1, memwb_flush: 1'b1};
    return c;
  endfunction

  // Memory freeze: hold everything, push a bubble into WB.
  function automatic hz_ctrl_t ctrl_freeze();
    hz_ctrl_t c;
    c = '0;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

  // Normal flow: everything advances.
  function automatic hz_ctrl_t ctrl_run();
    hz_ctrl_t c;
    c = '0;
    c.pc_write    = 1'b1;
    c.ifid_write  = 1'b1;
    c.idex_write  = 1'b1;
    c.exmem_write = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. When clear and increment
// are both asserted the counter restarts at one.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] base;
  logic [W-1:0] count_d;

  // Next value: optional clear, then increment unless already at all-ones.
  always_comb begin
    base    = clr ? '0 : count;
    count_d = base;
    if (inc && (base != '1)) count_d = base + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= count_d;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Enables and
// flushes are combinational from state and hazard inputs; state and
// counters are registered. Flush beats write inside each pipeline register.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int WAIT_LIMIT  = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_src,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  hz_state_e         state_q, state_d;
  hz_ctrl_t          ctrl, ctrl_resolve;
  logic [INIT_W-1:0] init_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_ahead;
  logic              load_use;
  logic              frozen;
  logic              branch_fire;

  assign load_use = idex_memread && (idex_rd != '0) &&
                    (((idex_rd == ifid_rs1) && ifid_use_rs1) ||
                     ((idex_rd == ifid_rs2) && ifid_use_rs2));

  // Branch / load-use / normal flow resolution, shared by RUN and the
  // MEM_WAIT release cycle. A taken branch squashes the dependent instruction.
  always_comb begin
    ctrl_resolve = ctrl_run();
    if (branch_taken) begin
      ctrl_resolve.pc_src      = 1'b1;
      ctrl_resolve.ifid_flush  = 1'b1;
      ctrl_resolve.idex_flush  = 1'b1;
      ctrl_resolve.exmem_flush = 1'b1;
    end else if (load_use) begin
      ctrl_resolve.pc_write   = 1'b0;
      ctrl_resolve.ifid_write = 1'b0;
      ctrl_resolve.idex_flush = 1'b1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    ctrl        = ctrl_init();
    frozen      = 1'b0;
    branch_fire = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          frozen  = 1'b1;
          ctrl    = ctrl_freeze();
          state_d = ST_MEM_WAIT;
        end else begin
          ctrl        = ctrl_resolve;
          branch_fire = branch_taken;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          frozen = 1'b1;
          ctrl   = ctrl_freeze();
        end else begin
          ctrl        = ctrl_resolve;
          branch_fire = branch_taken;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Priming counter: only advances while in INIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               init_cnt <= '0;
    else if (state_q == ST_INIT) init_cnt <= init_cnt + INIT_W'(1);
  end

  // Wait counter restarts at one on the cycle the freeze begins.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state_q == ST_RUN) && frozen),
    .inc     (frozen),
    .count   (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     ((state_q != ST_INIT) && !ctrl.pc_write),
    .count   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (branch_fire),
    .count   (flush_cnt)
  );

  // Value the wait counter holds after this edge.
  assign wait_ahead = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, frozen};

  // Sticky timeout flag; purely informational, sequencing ignores it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_timeout <= 1'b0;
    else if ((state_q == ST_MEM_WAIT) && (wait_ahead >= (WAIT_W + 1)'(WAIT_LIMIT)))
      mem_timeout <= 1'b1;
  end

  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_write  = ctrl.idex_write;
  assign exmem_write = ctrl.exmem_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random
// hazard traffic, all checked against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int INIT_CYCLES = 2;
  localparam int WAIT_LIMIT  = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
  logic        ifid_use_rs1, ifid_use_rs2, idex_memread;
  logic        branch_taken, dmem_req, dmem_ready;
  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_src;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_timeout;

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .pc_src(pc_src),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycles of priming left, whether a memory access is
  // outstanding, frozen-cycle count of that access, statistics, timeout.
  int  m_init_left;
  bit  m_waiting;
  int  m_wait;
  int  m_stall, m_flush;
  bit  m_tmo;
  // Per-cycle decisions, bit order:
  // {pc_write, pc_src, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f}
  logic [8:0] m_ctrl;
  bit  m_frozen, m_branch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init_left = INIT_CYCLES;
    m_waiting = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
  endtask

  // Decide what the pipeline should do this cycle from the hazard rules.
  task automatic model_eval();
    bit dep;
    m_frozen = 0; m_branch = 0;
    dep = idex_memread && idex_rd != 0 &&
          ((idex_rd == ifid_rs1 && ifid_use_rs1) || (idex_rd == ifid_rs2 && ifid_use_rs2));
    if (!reset_n || m_init_left > 0) m_ctrl = 9'b0_0000_1111;
    else begin
      m_frozen = m_waiting ? !dmem_ready : (dmem_req && !dmem_ready);
      if (m_frozen)          m_ctrl = 9'b0_0000_0001;
      else if (branch_taken) begin m_ctrl = 9'b1_1111_1110; m_branch = 1; end
      else if (dep)          m_ctrl = 9'b0_0011_0100;
      else                   m_ctrl = 9'b1_0111_0000;
    end
  endtask

  task automatic model_update();
    if (m_init_left > 0) begin
      m_init_left--;
      return;
    end
    if (!m_ctrl[8]) m_stall++;
    if (m_branch) m_flush++;
    if (!m_waiting) begin
      if (m_frozen) begin m_waiting = 1; m_wait = 1; end
    end else begin
      if (m_frozen && m_wait < 65535) m_wait++;
      if (m_wait >= WAIT_LIMIT) m_tmo = 1;
      if (!m_frozen) m_waiting = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [8:0] obs;
    int exp_state;
    model_eval();
    obs = {pc_write, pc_src, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_flush};
    exp_state = (!reset_n || m_init_left > 0) ? 0 : (m_waiting ? 2 : 1);
    chk({tag, "_ctrl"},  32'(obs), 32'(m_ctrl));
    chk({tag, "_state"}, 32'(state), 32'(exp_state));
    chk({tag, "_stall"}, stall_cnt, 32'(m_stall));
    chk({tag, "_flush"}, flush_cnt, 32'(m_flush));
    chk({tag, "_tmo"},   32'(mem_timeout), 32'(m_tmo));
  endtask

  // Driver tasks: called at a falling edge with inputs already applied.
  task automatic step(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1 check_all("reset");
    repeat (2) @(negedge clk);
    check_all("reset_hold");
    reset_n = 1'b1;
  endtask

  task automatic idle();
    ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    idex_rd = 0; idex_memread = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Priming then first RUN cycle
    step("init0"); step("init1");
    chk("run_state", 32'(state), 32'd1);
    step("run0");

    // Load-use on rs2, then the same with x0 as destination
    idex_memread = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
    #1 chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_idex_flush", 32'(idex_flush), 32'd1);
    step("loaduse");
    idle();
    step("lu_after");
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    idex_memread = 1; idex_rd = 0; ifid_rs2 = 0; ifid_use_rs2 = 1;
    step("lu_x0");
    chk("lu_x0_stall_cnt", stall_cnt, 32'd1);

    // Branch flush
    idle(); branch_taken = 1;
    step("branch");
    idle();
    step("br_after");
    chk("br_flush_cnt", flush_cnt, 32'd1);
    chk("br_stall_cnt", stall_cnt, 32'd1);

    // Memory wait of three frozen cycles, then release
    dmem_req = 1;
    repeat (3) step("memwait");
    chk("mw_stall_cnt", stall_cnt, 32'd4);
    chk("mw_state", 32'(state), 32'd2);
    dmem_ready = 1;
    step("mw_release");
    idle();
    chk("mw_release_state", 32'(state), 32'd1);

    // Branch arriving with a pending memory access
    dmem_req = 1; branch_taken = 1;
    step("brmem_freeze");
    #1 chk("brmem_pc_src_held", 32'(pc_src), 32'd0);
    step("brmem_freeze2");
    dmem_ready = 1;
    #1 chk("brmem_pc_src_release", 32'(pc_src), 32'd1);
    step("brmem_release");
    idle();
    chk("brmem_flush_cnt", flush_cnt, 32'd2);

    // Timeout with ready held low
    do_reset();
    step("init0"); step("init1");
    dmem_req = 1;
    repeat (3) step("tmo_wait");
    chk("tmo_before", 32'(mem_timeout), 32'd0);
    step("tmo_wait4");
    chk("tmo_raised", 32'(mem_timeout), 32'd1);
    step("tmo_wait5");
    dmem_ready = 1;
    step("tmo_release");
    idle();
    step("tmo_sticky");
    chk("tmo_sticky_run", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a memory wait
    dmem_req = 1;
    repeat (2) step("mid_wait");
    do_reset();
    idle();
    step("init0"); step("init1");

    // Random hazard traffic
    for (int i = 0; i < 500; i++) begin
      ifid_rs1     = 5'($urandom_range(0, 3));
      ifid_rs2     = 5'($urandom_range(0, 3));
      ifid_use_rs1 = 1'($urandom_range(0, 1));
      ifid_use_rs2 = 1'($urandom_range(0, 1));
      idex_rd      = 5'($urandom_range(0, 3));
      idex_memread = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 5) == 0);
      dmem_req     = m_waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
      dmem_ready   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
